// File: rtl/output_act_ctrl_if.sv
// Activation write-back bus: compute-array byte stream in, host-side FIFO read port out.
// The slave modport is the packer/FIFO; the master modport is whoever drives bytes and pops words.
interface output_act_ctrl_if #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 64
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                    CLEAR_FIFO;
    logic [INPUT_WIDTH-1:0]  OUT_ACT_DATA_IN;
    logic                    DATA_VALID;
    logic                    FLUSH;
    logic                    FIFO_RD_CMD;
    logic [OUTPUT_WIDTH-1:0] FIFO_RD_DATA;
    logic                    FIFO_EMPTY;
    logic                    FIFO_FULL;
    logic [CW-1:0]           WORD_COUNT;
    logic [1:0]              LANE_IDX;
    logic                    OVERFLOW;

    modport master (
        output CLEAR_FIFO, OUT_ACT_DATA_IN, DATA_VALID, FLUSH, FIFO_RD_CMD,
        input  FIFO_RD_DATA, FIFO_EMPTY, FIFO_FULL, WORD_COUNT, LANE_IDX, OVERFLOW
    );

    modport slave (
        input  CLEAR_FIFO, OUT_ACT_DATA_IN, DATA_VALID, FLUSH, FIFO_RD_CMD,
        output FIFO_RD_DATA, FIFO_EMPTY, FIFO_FULL, WORD_COUNT, LANE_IDX, OVERFLOW
    );
endinterface

// File: rtl/output_act_ctrl.sv
// Packs a byte stream (first byte in [7:0]) into 32-bit words and buffers them in a fall-through FIFO.
// Latency: completing byte at edge N is readable after edge N. No input backpressure: words pushed into a full FIFO are dropped and flagged sticky OVERFLOW.
module output_act_ctrl #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output_act_ctrl_if.slave      bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int LANES = 4;

    logic [OUTPUT_WIDTH-1:0] shadow_q, shadow_d;
    logic [1:0]              lane_q, lane_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ovf_q, ovf_d;

    logic [OUTPUT_WIDTH-1:0] word_cur;
    logic                    complete;
    logic                    flush_push;
    logic                    push_req;
    logic                    pop;
    logic                    full;
    logic                    accept;
    logic                    mem_we;

    // Storage is deliberately left unreset; validity is tracked by count/pointers only.
    logic [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];

    always_comb begin
        word_cur   = shadow_q;
        for (int i = 0; i < LANES; i++) begin
            if (bus.DATA_VALID && lane_q == 2'(i)) begin
                word_cur[i*INPUT_WIDTH +: INPUT_WIDTH] = bus.OUT_ACT_DATA_IN;
            end
        end

        complete   = bus.DATA_VALID && (lane_q == 2'd3);
        // Flush only pushes when something is left in the shadow after this cycle's byte.
        flush_push = bus.FLUSH && (bus.DATA_VALID ? (lane_q != 2'd3) : (lane_q != 2'd0));
        push_req   = complete || flush_push;
        pop        = bus.FIFO_RD_CMD && (count_q != '0);
        full       = (count_q == CW'(FIFO_DEPTH));
        accept     = push_req && (!full || pop);

        shadow_d   = shadow_q;
        lane_d     = lane_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        mem_we     = accept;

        if (push_req) begin
            shadow_d = '0;
            lane_d   = 2'd0;
        end else if (bus.DATA_VALID) begin
            shadow_d = word_cur;
            lane_d   = lane_q + 2'd1;
        end

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(accept) - CW'(pop);

        if (push_req && !accept) begin
            ovf_d = 1'b1;
        end

        if (bus.CLEAR_FIFO) begin
            shadow_d = '0;
            lane_d   = 2'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            mem_we   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shadow_q <= '0;
            lane_q   <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= word_cur;
        end
    end

    assign bus.FIFO_RD_DATA = (count_q == '0) ? '0 : mem[rd_ptr_q];
    assign bus.FIFO_EMPTY   = (count_q == '0);
    assign bus.FIFO_FULL    = full;
    assign bus.WORD_COUNT   = count_q;
    assign bus.LANE_IDX     = lane_q;
    assign bus.OVERFLOW     = ovf_q;
endmodule

// File: tb/tb_output_act_ctrl.sv
// Directed bench for output_act_ctrl: packing, flush, full/overflow, wrap, clear and async reset.
module tb_output_act_ctrl;
    logic CLK;
    logic RESET;
    int   passed = 0;
    int   total  = 0;

    output_act_ctrl_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .FIFO_DEPTH(64)) bus ();

    output_act_ctrl #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .FIFO_DEPTH(64)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] exp_word(input int w);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    // One clock of stimulus; inputs return to idle 1 ns after the edge.
    task automatic drive(input logic v, input logic [7:0] b, input logic fl, input logic rd, input logic clr);
        bus.DATA_VALID      = v;
        bus.OUT_ACT_DATA_IN = b;
        bus.FLUSH           = fl;
        bus.FIFO_RD_CMD     = rd;
        bus.CLEAR_FIFO      = clr;
        @(posedge CLK);
        #1;
        bus.DATA_VALID      = 1'b0;
        bus.OUT_ACT_DATA_IN = 8'h00;
        bus.FLUSH           = 1'b0;
        bus.FIFO_RD_CMD     = 1'b0;
        bus.CLEAR_FIFO      = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL reset_empty got %b exp 1", bus.FIFO_EMPTY); else passed++;
        total++; if (bus.FIFO_FULL !== 1'b0) $display("FAIL reset_full got %b exp 0", bus.FIFO_FULL); else passed++;
        total++; if (bus.WORD_COUNT !== 7'd0) $display("FAIL reset_count got %0d exp 0", bus.WORD_COUNT); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL reset_lane got %0d exp 0", bus.LANE_IDX); else passed++;
        total++; if (bus.OVERFLOW !== 1'b0) $display("FAIL reset_ovf got %b exp 0", bus.OVERFLOW); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h0) $display("FAIL reset_data got %h exp 0", bus.FIFO_RD_DATA); else passed++;
        #3 RESET = 1'b0;
    endtask

    task automatic test_basic();
        drive(1, 8'h11, 0, 0, 0);
        total++; if (bus.LANE_IDX !== 2'd1) $display("FAIL basic_lane1 got %0d exp 1", bus.LANE_IDX); else passed++;
        drive(1, 8'h22, 0, 0, 0);
        drive(1, 8'h33, 0, 0, 0);
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL basic_empty3 got %b exp 1", bus.FIFO_EMPTY); else passed++;
        drive(1, 8'h44, 0, 0, 0);
        total++; if (bus.FIFO_EMPTY !== 1'b0) $display("FAIL basic_empty got %b exp 0", bus.FIFO_EMPTY); else passed++;
        total++; if (bus.WORD_COUNT !== 7'd1) $display("FAIL basic_count got %0d exp 1", bus.WORD_COUNT); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h44332211) $display("FAIL basic_data got %h exp 44332211", bus.FIFO_RD_DATA); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL basic_lane0 got %0d exp 0", bus.LANE_IDX); else passed++;
        drive(0, 8'h00, 0, 1, 0);
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL basic_pop_empty got %b exp 1", bus.FIFO_EMPTY); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h0) $display("FAIL basic_pop_data got %h exp 0", bus.FIFO_RD_DATA); else passed++;
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] w;
        int sent = 0;
        while (sent < 84) begin
            if ($urandom_range(0, 2) != 0) begin
                b = 8'($urandom);
                q.push_back(b);
                drive(1, b, 0, 0, 0);
                sent++;
            end else begin
                drive(0, 8'h00, 0, 0, 0);
            end
        end
        total++; if (bus.WORD_COUNT !== 7'd21) $display("FAIL rand_count got %0d exp 21", bus.WORD_COUNT); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL rand_lane got %0d exp 0", bus.LANE_IDX); else passed++;
        for (int k = 0; k < 21; k++) begin
            w = {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]};
            total++; if (bus.FIFO_RD_DATA !== w) $display("FAIL rand_word%0d got %h exp %h", k, bus.FIFO_RD_DATA, w); else passed++;
            drive(0, 8'h00, 0, 1, 0);
        end
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL rand_drained got %b exp 1", bus.FIFO_EMPTY); else passed++;
    endtask

    task automatic test_flush();
        drive(1, 8'hAA, 0, 0, 0);
        drive(1, 8'hBB, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        total++; if (bus.WORD_COUNT !== 7'd1) $display("FAIL flush_count got %0d exp 1", bus.WORD_COUNT); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h0000BBAA) $display("FAIL flush_data got %h exp 0000bbaa", bus.FIFO_RD_DATA); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL flush_lane got %0d exp 0", bus.LANE_IDX); else passed++;
        drive(0, 8'h00, 1, 0, 0);
        total++; if (bus.WORD_COUNT !== 7'd1) $display("FAIL flush_idle got %0d exp 1", bus.WORD_COUNT); else passed++;
        drive(0, 8'h00, 0, 1, 0);
        drive(1, 8'hA1, 0, 0, 0);
        drive(1, 8'hB2, 0, 0, 0);
        drive(1, 8'hC3, 0, 0, 0);
        drive(1, 8'hDD, 1, 0, 0);
        total++; if (bus.WORD_COUNT !== 7'd1) $display("FAIL flush4_count got %0d exp 1", bus.WORD_COUNT); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'hDDC3B2A1) $display("FAIL flush4_data got %h exp ddc3b2a1", bus.FIFO_RD_DATA); else passed++;
        drive(0, 8'h00, 0, 1, 0);
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL flush4_drain got %b exp 1", bus.FIFO_EMPTY); else passed++;
    endtask

    task automatic test_full_overflow();
        for (int w = 0; w < 64; w++) begin
            for (int j = 0; j < 4; j++) drive(1, 8'(4*w+j), 0, 0, 0);
        end
        total++; if (bus.FIFO_FULL !== 1'b1) $display("FAIL full_flag got %b exp 1", bus.FIFO_FULL); else passed++;
        total++; if (bus.WORD_COUNT !== 7'd64) $display("FAIL full_count got %0d exp 64", bus.WORD_COUNT); else passed++;
        total++; if (bus.OVERFLOW !== 1'b0) $display("FAIL full_noovf got %b exp 0", bus.OVERFLOW); else passed++;
        for (int j = 0; j < 4; j++) drive(1, 8'(4*64+j), 0, 0, 0);
        total++; if (bus.OVERFLOW !== 1'b1) $display("FAIL ovf_set got %b exp 1", bus.OVERFLOW); else passed++;
        total++; if (bus.WORD_COUNT !== 7'd64) $display("FAIL ovf_count got %0d exp 64", bus.WORD_COUNT); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL ovf_lane got %0d exp 0", bus.LANE_IDX); else passed++;
        total++; if (bus.FIFO_RD_DATA !== exp_word(0)) $display("FAIL ovf_head got %h exp %h", bus.FIFO_RD_DATA, exp_word(0)); else passed++;
        for (int j = 0; j < 3; j++) drive(1, 8'(4*65+j), 0, 0, 0);
        drive(1, 8'(4*65+3), 0, 1, 0);
        total++; if (bus.WORD_COUNT !== 7'd64) $display("FAIL pushpop_count got %0d exp 64", bus.WORD_COUNT); else passed++;
        total++; if (bus.FIFO_FULL !== 1'b1) $display("FAIL pushpop_full got %b exp 1", bus.FIFO_FULL); else passed++;
        for (int k = 0; k < 64; k++) begin
            if (bus.FIFO_RD_DATA !== exp_word(k < 63 ? k + 1 : 65)) begin
                total++;
                $display("FAIL wrap_word%0d got %h exp %h", k, bus.FIFO_RD_DATA, exp_word(k < 63 ? k + 1 : 65));
            end else begin
                total++;
                passed++;
            end
            drive(0, 8'h00, 0, 1, 0);
        end
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL wrap_drained got %b exp 1", bus.FIFO_EMPTY); else passed++;
        total++; if (bus.OVERFLOW !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.OVERFLOW); else passed++;
    endtask

    task automatic test_empty_pop_push();
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'h02, 0, 0, 0);
        drive(1, 8'h03, 0, 0, 0);
        drive(1, 8'h04, 0, 1, 0);
        total++; if (bus.WORD_COUNT !== 7'd1) $display("FAIL emptypop_count got %0d exp 1", bus.WORD_COUNT); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h04030201) $display("FAIL emptypop_head got %h exp 04030201", bus.FIFO_RD_DATA); else passed++;
    endtask

    task automatic test_clear();
        drive(1, 8'h77, 0, 0, 0);
        drive(1, 8'h88, 0, 0, 0);
        drive(1, 8'h99, 1, 1, 1);
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL clear_empty got %b exp 1", bus.FIFO_EMPTY); else passed++;
        total++; if (bus.WORD_COUNT !== 7'd0) $display("FAIL clear_count got %0d exp 0", bus.WORD_COUNT); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL clear_lane got %0d exp 0", bus.LANE_IDX); else passed++;
        total++; if (bus.OVERFLOW !== 1'b0) $display("FAIL clear_ovf got %b exp 0", bus.OVERFLOW); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h0) $display("FAIL clear_data got %h exp 0", bus.FIFO_RD_DATA); else passed++;
        drive(1, 8'h5A, 1, 0, 0);
        total++; if (bus.FIFO_RD_DATA !== 32'h0000005A) $display("FAIL clear_shadow got %h exp 0000005a", bus.FIFO_RD_DATA); else passed++;
        drive(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int j = 0; j < 10; j++) drive(1, 8'(8'hC0 + j), 0, 0, 0);
        total++; if (bus.WORD_COUNT !== 7'd2) $display("FAIL arst_pre_count got %0d exp 2", bus.WORD_COUNT); else passed++;
        #3 RESET = 1'b1;
        #1;
        total++; if (bus.FIFO_EMPTY !== 1'b1) $display("FAIL arst_empty got %b exp 1", bus.FIFO_EMPTY); else passed++;
        total++; if (bus.WORD_COUNT !== 7'd0) $display("FAIL arst_count got %0d exp 0", bus.WORD_COUNT); else passed++;
        total++; if (bus.LANE_IDX !== 2'd0) $display("FAIL arst_lane got %0d exp 0", bus.LANE_IDX); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'h0) $display("FAIL arst_data got %h exp 0", bus.FIFO_RD_DATA); else passed++;
        #2 RESET = 1'b0;
        @(posedge CLK);
        #1;
        drive(1, 8'hE1, 0, 0, 0);
        drive(1, 8'hE2, 0, 0, 0);
        drive(1, 8'hE3, 0, 0, 0);
        drive(1, 8'hE4, 0, 0, 0);
        total++; if (bus.WORD_COUNT !== 7'd1) $display("FAIL arst_post_count got %0d exp 1", bus.WORD_COUNT); else passed++;
        total++; if (bus.FIFO_RD_DATA !== 32'hE4E3E2E1) $display("FAIL arst_post_data got %h exp e4e3e2e1", bus.FIFO_RD_DATA); else passed++;
    endtask

    initial begin
        bus.DATA_VALID      = 1'b0;
        bus.OUT_ACT_DATA_IN = 8'h00;
        bus.FLUSH           = 1'b0;
        bus.FIFO_RD_CMD     = 1'b0;
        bus.CLEAR_FIFO      = 1'b0;
        test_reset();
        @(posedge CLK);
        #1;
        test_basic();
        test_random_stream();
        test_flush();
        test_full_overflow();
        test_empty_pop_push();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
